// File: rtl/bus_control_sequencer_if.sv
// Handshake and bus-control bundle between the control sequencer and the datapath.
//   opcode       : IR opcode field, sampled by the sequencer in DECODE
//   memReady     : memory completes the current read/write this cycle
//   busEnable    : one-hot drive enables {alu,acc,mdr,irOperand,pc}; 0 = bus floats
//   regLoad      : load strobes {pc,acc,tmp,mdr,ir,mar}
//   pcIncrement  : PC += 1 at the next edge
//   memRead      : memory read request (MAR address -> MDR)
//   memWrite     : memory write request (MDR -> mem[MAR])
//   aluSub       : 1 = ALU computes ACC-TMP, 0 = ACC+TMP
//   halted       : sequencer in HALT or FAULT
//   memFault     : sequencer in FAULT
// master = sequencer side, slave = datapath/memory side.
interface bus_control_sequencer_if #(
  parameter int OPCODE_WIDTH = 4
);
  logic [OPCODE_WIDTH-1:0] opcode;
  logic                    memReady;
  logic [4:0]              busEnable;
  logic [5:0]              regLoad;
  logic                    pcIncrement;
  logic                    memRead;
  logic                    memWrite;
  logic                    aluSub;
  logic                    halted;
  logic                    memFault;

  modport master (
    input  opcode, memReady,
    output busEnable, regLoad, pcIncrement, memRead, memWrite, aluSub, halted, memFault
  );

  modport slave (
    output opcode, memReady,
    input  busEnable, regLoad, pcIncrement, memRead, memWrite, aluSub, halted, memFault
  );
endinterface

// File: rtl/bus_control_sequencer.sv
// Fetch/decode/execute control FSM for the shared-bus CPU datapath.
// Drives one-hot bus enables, register load strobes and the memory handshake.
// A memory access that stalls too long ends in a sticky FAULT halt.
// Ports:
//   clk    : system clock, all state on posedge
//   reset  : synchronous active-high reset
//   bus    : bus_control_sequencer_if.master (opcode/memReady in, controls out)
module bus_control_sequencer #(
  parameter int OPCODE_WIDTH = 4,
  parameter int MEM_TIMEOUT  = 15
) (
  input  logic                    clk,
  input  logic                    reset,
  bus_control_sequencer_if.master bus
);
  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  localparam logic [OPCODE_WIDTH-1:0] OP_LDA = OPCODE_WIDTH'(1);
  localparam logic [OPCODE_WIDTH-1:0] OP_STA = OPCODE_WIDTH'(2);
  localparam logic [OPCODE_WIDTH-1:0] OP_ADD = OPCODE_WIDTH'(3);
  localparam logic [OPCODE_WIDTH-1:0] OP_SUB = OPCODE_WIDTH'(4);
  localparam logic [OPCODE_WIDTH-1:0] OP_JMP = OPCODE_WIDTH'(5);
  localparam logic [OPCODE_WIDTH-1:0] OP_HLT = {OPCODE_WIDTH{1'b1}};

  // busEnable bits {alu,acc,mdr,irOperand,pc}
  localparam logic [4:0] BE_PC  = 5'b00001;
  localparam logic [4:0] BE_IR  = 5'b00010;
  localparam logic [4:0] BE_MDR = 5'b00100;
  localparam logic [4:0] BE_ACC = 5'b01000;
  localparam logic [4:0] BE_ALU = 5'b10000;
  // regLoad bits {pc,acc,tmp,mdr,ir,mar}
  localparam logic [5:0] RL_MAR = 6'b000001;
  localparam logic [5:0] RL_IR  = 6'b000010;
  localparam logic [5:0] RL_MDR = 6'b000100;
  localparam logic [5:0] RL_TMP = 6'b001000;
  localparam logic [5:0] RL_ACC = 6'b010000;
  localparam logic [5:0] RL_PC  = 6'b100000;

  typedef enum logic [3:0] {
    S_RESET, S_FETCH_ADDR, S_FETCH_MEM, S_FETCH_IR, S_DECODE,
    S_EXEC_ADDR, S_EXEC_MEM, S_EXEC_LDACC, S_EXEC_TMP, S_EXEC_ALU,
    S_EXEC_STMDR, S_EXEC_WRITE, S_EXEC_JMP, S_HALT, S_FAULT
  } state_t;

  state_t                  state_reg, state_next;
  logic [WAIT_W-1:0]       wait_reg, wait_next;
  logic [OPCODE_WIDTH-1:0] op_reg, op_next;

  logic [4:0] bus_enable;
  logic [5:0] reg_load;
  logic       pc_increment, mem_read, mem_write, alu_sub, halted, mem_fault;
  logic       mem_state, timeout;

  // Last allowed stall cycle; memReady=1 in this cycle still completes normally.
  assign timeout   = (wait_reg == WAIT_W'(MEM_TIMEOUT - 1));
  assign mem_state = (state_reg == S_FETCH_MEM) || (state_reg == S_EXEC_MEM) ||
                     (state_reg == S_EXEC_WRITE);
  // Staying in a memory state only happens on a stall; any transition restarts the count.
  assign wait_next = (mem_state && (state_next == state_reg)) ? wait_reg + WAIT_W'(1) : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_RESET;
      wait_reg  <= '0;
      op_reg    <= '0;
    end else begin
      state_reg <= state_next;
      wait_reg  <= wait_next;
      op_reg    <= op_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    op_next      = op_reg;
    bus_enable   = '0;
    reg_load     = '0;
    pc_increment = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    alu_sub      = 1'b0;
    halted       = 1'b0;
    mem_fault    = 1'b0;
    case (state_reg)
      S_RESET: state_next = S_FETCH_ADDR;
      S_FETCH_ADDR: begin
        bus_enable = BE_PC;
        reg_load   = RL_MAR;
        state_next = S_FETCH_MEM;
      end
      S_FETCH_MEM: begin
        mem_read = 1'b1;
        if (bus.memReady) begin
          pc_increment = 1'b1;
          state_next   = S_FETCH_IR;
        end else if (timeout) begin
          state_next = S_FAULT;
        end
      end
      S_FETCH_IR: begin
        bus_enable = BE_MDR;
        reg_load   = RL_IR;
        state_next = S_DECODE;
      end
      S_DECODE: begin
        // Capture the opcode so later IR/opcode changes cannot redirect this instruction.
        op_next = bus.opcode;
        case (bus.opcode)
          OP_LDA, OP_STA, OP_ADD, OP_SUB: state_next = S_EXEC_ADDR;
          OP_JMP:                         state_next = S_EXEC_JMP;
          OP_HLT:                         state_next = S_HALT;
          default:                        state_next = S_FETCH_ADDR;
        endcase
      end
      S_EXEC_ADDR: begin
        bus_enable = BE_IR;
        reg_load   = RL_MAR;
        state_next = (op_reg == OP_STA) ? S_EXEC_STMDR : S_EXEC_MEM;
      end
      S_EXEC_MEM: begin
        mem_read = 1'b1;
        if (bus.memReady) begin
          state_next = (op_reg == OP_LDA) ? S_EXEC_LDACC : S_EXEC_TMP;
        end else if (timeout) begin
          state_next = S_FAULT;
        end
      end
      S_EXEC_LDACC: begin
        bus_enable = BE_MDR;
        reg_load   = RL_ACC;
        state_next = S_FETCH_ADDR;
      end
      S_EXEC_TMP: begin
        bus_enable = BE_MDR;
        reg_load   = RL_TMP;
        state_next = S_EXEC_ALU;
      end
      S_EXEC_ALU: begin
        bus_enable = BE_ALU;
        reg_load   = RL_ACC;
        alu_sub    = (op_reg == OP_SUB);
        state_next = S_FETCH_ADDR;
      end
      S_EXEC_STMDR: begin
        bus_enable = BE_ACC;
        reg_load   = RL_MDR;
        state_next = S_EXEC_WRITE;
      end
      S_EXEC_WRITE: begin
        mem_write = 1'b1;
        if (bus.memReady) begin
          state_next = S_FETCH_ADDR;
        end else if (timeout) begin
          state_next = S_FAULT;
        end
      end
      S_EXEC_JMP: begin
        bus_enable = BE_IR;
        reg_load   = RL_PC;
        state_next = S_FETCH_ADDR;
      end
      S_HALT: halted = 1'b1;
      S_FAULT: begin
        halted    = 1'b1;
        mem_fault = 1'b1;
      end
      default: state_next = S_RESET;
    endcase
  end

  assign bus.busEnable   = bus_enable;
  assign bus.regLoad     = reg_load;
  assign bus.pcIncrement = pc_increment;
  assign bus.memRead     = mem_read;
  assign bus.memWrite    = mem_write;
  assign bus.aluSub      = alu_sub;
  assign bus.halted      = halted;
  assign bus.memFault    = mem_fault;
endmodule

// File: tb/tb_bus_control_sequencer.sv
module tb_bus_control_sequencer;
  localparam int OW = 4;
  localparam int TO = 15;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  bus_control_sequencer_if #(.OPCODE_WIDTH(OW)) bus_if ();

  bus_control_sequencer #(.OPCODE_WIDTH(OW), .MEM_TIMEOUT(TO)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_if)
  );

  // One micro-step of an instruction, as listed in the instruction table.
  typedef struct packed {
    logic [4:0] be;
    logic [5:0] rl;
    logic       rd;
    logic       wr;
    logic       sub;
    logic       mem;    // waits on memReady
    logic       fetch;  // instruction fetch read: pcIncrement with memReady
    logic       dec;    // decode point: opcode chooses the following steps
  } step_t;

  typedef enum int {M_RESET, M_RUN, M_HALT, M_FAULT} mode_t;

  int    tests = 0;
  int    fails = 0;
  step_t q[$];
  mode_t mode = M_RESET;
  bit    valid = 1'b0;
  int    waitc = 0;
  logic [16:0] obs;  // {be[4:0], rl[5:0], pcinc, rd, wr, sub, halted, fault}

  logic [4:0] hist_be  [0:39];
  logic [5:0] hist_rl  [0:39];
  logic       hist_sub [0:39];

  function automatic step_t mk(logic [4:0] be, logic [5:0] rl, logic rd, logic wr,
                               logic sub, logic mem, logic fetch, logic dec);
    step_t s;
    s = {be, rl, rd, wr, sub, mem, fetch, dec};
    return s;
  endfunction

  task automatic push_fetch();
    q.push_back(mk(5'b00001, 6'b000001, 0, 0, 0, 0, 0, 0));
    q.push_back(mk(5'b00000, 6'b000000, 1, 0, 0, 1, 1, 0));
    q.push_back(mk(5'b00100, 6'b000010, 0, 0, 0, 0, 0, 0));
    q.push_back(mk(5'b00000, 6'b000000, 0, 0, 0, 0, 0, 1));
  endtask

  task automatic push_exec(input logic [3:0] op);
    case (op)
      4'h1: begin
        q.push_back(mk(5'b00010, 6'b000001, 0, 0, 0, 0, 0, 0));
        q.push_back(mk(5'b00000, 6'b000000, 1, 0, 0, 1, 0, 0));
        q.push_back(mk(5'b00100, 6'b010000, 0, 0, 0, 0, 0, 0));
      end
      4'h2: begin
        q.push_back(mk(5'b00010, 6'b000001, 0, 0, 0, 0, 0, 0));
        q.push_back(mk(5'b01000, 6'b000100, 0, 0, 0, 0, 0, 0));
        q.push_back(mk(5'b00000, 6'b000000, 0, 1, 0, 1, 0, 0));
      end
      4'h3, 4'h4: begin
        q.push_back(mk(5'b00010, 6'b000001, 0, 0, 0, 0, 0, 0));
        q.push_back(mk(5'b00000, 6'b000000, 1, 0, 0, 1, 0, 0));
        q.push_back(mk(5'b00100, 6'b001000, 0, 0, 0, 0, 0, 0));
        q.push_back(mk(5'b10000, 6'b010000, 0, 0, (op == 4'h4), 0, 0, 0));
      end
      4'h5: q.push_back(mk(5'b00010, 6'b100000, 0, 0, 0, 0, 0, 0));
      4'hF: mode = M_HALT;
      default: ;
    endcase
  endtask

  task automatic model_update(input logic r, input logic [3:0] op, input logic rdy);
    step_t s;
    if (r) begin
      mode  = M_RESET;
      q.delete();
      waitc = 0;
      valid = 1'b1;
    end else if (valid) begin
      case (mode)
        M_RESET: begin
          mode = M_RUN;
          push_fetch();
        end
        M_RUN: begin
          s = q[0];
          if (s.mem && !rdy) begin
            waitc++;
            if (waitc == TO) begin
              mode = M_FAULT;
              q.delete();
            end
          end else begin
            waitc = 0;
            void'(q.pop_front());
            if (s.dec) push_exec(op);
            if (mode == M_RUN && q.size() == 0) push_fetch();
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  // One clock: drive inputs after the falling edge, sample, compare, advance the model.
  task automatic cycle(input logic r, input logic [3:0] op, input logic rdy);
    logic [16:0] exp;
    step_t s;
    @(negedge clk);
    reset           = r;
    bus_if.opcode   = op;
    bus_if.memReady = rdy;
    #1;
    obs = {bus_if.busEnable, bus_if.regLoad, bus_if.pcIncrement, bus_if.memRead,
           bus_if.memWrite, bus_if.aluSub, bus_if.halted, bus_if.memFault};
    if (valid) begin
      exp = '0;
      case (mode)
        M_HALT:  exp[1]   = 1'b1;
        M_FAULT: exp[1:0] = 2'b11;
        M_RUN: begin
          s   = q[0];
          exp = {s.be, s.rl, s.fetch & rdy, s.rd, s.wr, s.sub, 2'b00};
        end
        default: ;
      endcase
      check("outputs", 32'(obs), 32'(exp));
      check("onehot0_busEnable", 32'($onehot0(obs[16:12])), 32'd1);
      check("no_rd_wr_overlap", 32'(obs[4] & obs[3]), 32'd0);
      check("no_pcinc_pcload", 32'(obs[5] & obs[11]), 32'd0);
    end
    model_update(r, op, rdy);
  endtask

  // Run from a FETCH_ADDR cycle (already sampled) to the next FETCH_ADDR.
  // Opcode is replaced by its complement after DECODE; memReady low in [stall_at, stall_at+stall_len).
  task automatic run_instr(input logic [3:0] op, input int stall_at, input int stall_len,
                           output int n, output int wr_cnt);
    logic       rdy;
    logic [3:0] o;
    hist_be[0]  = obs[16:12];
    hist_rl[0]  = obs[11:6];
    hist_sub[0] = obs[2];
    n      = -1;
    wr_cnt = 0;
    for (int i = 1; i < 40; i++) begin
      rdy = !(i >= stall_at && i < stall_at + stall_len);
      o   = (i <= 3) ? op : ~op;
      cycle(1'b0, o, rdy);
      if (obs[16:12] == 5'b00001 && obs[11:6] == 6'b000001) begin
        n = i;
        break;
      end
      hist_be[i]  = obs[16:12];
      hist_rl[i]  = obs[11:6];
      hist_sub[i] = obs[2];
      wr_cnt += int'(obs[3]);
    end
  endtask

  initial begin
    int n, wr_cnt, rd_cnt, stuck, burst;
    logic r, rdy;
    bus_if.opcode   = '0;
    bus_if.memReady = 1'b0;

    // 1: reset, then RESET cycle and first FETCH_ADDR
    cycle(1'b1, 4'h0, 1'b0);
    cycle(1'b1, 4'h0, 1'b0);
    cycle(1'b0, 4'h1, 1'b1);
    check("reset_cycle0_all_zero", 32'(obs), 32'd0);
    cycle(1'b0, 4'h1, 1'b1);
    check("cycle1_busEnable", 32'(obs[16:12]), 32'b00001);
    check("cycle1_regLoad", 32'(obs[11:6]), 32'b000001);

    // 2: LDA
    run_instr(4'h1, 99, 0, n, wr_cnt);
    check("lda_latency", n, 7);
    check("lda_ldacc_busEnable", 32'(hist_be[6]), 32'b00100);
    check("lda_ldacc_regLoad", 32'(hist_rl[6]), 32'b010000);

    // 3: SUB, then ADD
    run_instr(4'h4, 99, 0, n, wr_cnt);
    check("sub_latency", n, 8);
    check("sub_tmp_regLoad", 32'(hist_rl[6]), 32'b001000);
    check("sub_alu_busEnable", 32'(hist_be[7]), 32'b10000);
    check("sub_alu_aluSub", 32'(hist_sub[7]), 32'd1);
    run_instr(4'h3, 99, 0, n, wr_cnt);
    check("add_latency", n, 8);
    check("add_alu_aluSub", 32'(hist_sub[7]), 32'd0);

    // NOP, undefined opcode, JMP
    run_instr(4'h0, 99, 0, n, wr_cnt);
    check("nop_latency", n, 4);
    run_instr(4'h9, 99, 0, n, wr_cnt);
    check("undef_as_nop_latency", n, 4);
    run_instr(4'h5, 99, 0, n, wr_cnt);
    check("jmp_latency", n, 5);
    check("jmp_regLoad", 32'(hist_rl[4]), 32'b100000);

    // 4: STA with 3 wait cycles in EXEC_WRITE
    run_instr(4'h2, 6, 3, n, wr_cnt);
    check("sta_stalled_latency", n, 10);
    check("sta_memWrite_cycles", wr_cnt, 4);
    check("sta_no_fault", 32'(obs[0]), 32'd0);

    // 5: memReady stuck low in FETCH_MEM
    rd_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      cycle(1'b0, 4'h0, 1'b0);
      if (obs[1]) break;
      rd_cnt += int'(obs[4]);
    end
    check("fault_wait_cycles", rd_cnt, TO);
    check("fault_flags", 32'(obs[1:0]), 32'b11);
    for (int i = 0; i < 3; i++) cycle(1'b0, 4'h0, 1'b1);
    check("fault_sticky", 32'(obs[1:0]), 32'b11);
    cycle(1'b1, 4'h0, 1'b0);
    cycle(1'b0, 4'h0, 1'b0);
    check("reset_clears_fault", 32'(obs), 32'd0);
    cycle(1'b0, 4'hF, 1'b1);
    check("after_fault_fetch_addr", 32'(obs[16:6]), 32'b00001_000001);

    // 6: HLT, then reset out of HALT
    for (int i = 0; i < 3; i++) cycle(1'b0, 4'hF, 1'b1);
    for (int i = 0; i < 5; i++) cycle(1'b0, 4'h1, 1'b1);
    check("halt_halted", 32'(obs[1:0]), 32'b10);
    cycle(1'b1, 4'h0, 1'b1);
    cycle(1'b0, 4'h0, 1'b1);
    check("reset_from_halt_zero", 32'(obs), 32'd0);
    cycle(1'b0, 4'h0, 1'b1);
    check("after_halt_fetch_addr", 32'(obs[16:6]), 32'b00001_000001);

    // Random opcode/memReady run against the instruction-table model
    stuck = 0;
    burst = 0;
    for (int i = 0; i < 3000; i++) begin
      r = 1'b0;
      if (mode == M_HALT || mode == M_FAULT) stuck++;
      else stuck = 0;
      if (stuck >= 3 || $urandom_range(0, 399) == 0) r = 1'b1;
      if (burst > 0) begin
        rdy = 1'b0;
        burst--;
      end else begin
        rdy = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 149) == 0) burst = int'($urandom_range(10, 20));
      end
      cycle(r, 4'($urandom_range(0, 15)), rdy);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
